// File: rtl/sp_fifo_ctrl.sv
// FIFO controller front-ending a single-port 4x256 RAM.
// Push/pop contention is arbitrated round-robin, one RAM access per cycle.
module sp_fifo_ctrl #(
  parameter int DATA_W = 4,
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push_req,
  input  logic [DATA_W-1:0] push_data,
  output logic              push_ack,
  input  logic              pop_req,
  output logic              pop_ack,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   count,
  output logic              mem_wr_en,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wr_data,
  input  logic [DATA_W-1:0] mem_rd_data
);

  typedef enum logic {
    PRIO_WR,
    PRIO_RD
  } prio_t;

  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);

  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  prio_t             prio;
  logic              push_el;
  logic              pop_el;
  logic              grant_w;
  logic              grant_r;
  logic [ADDR_W:0]   count_nxt;

  always_comb begin
    push_el   = rst & push_req & ~full;
    pop_el    = rst & pop_req & ~empty;
    grant_w   = push_el & (~pop_el | (prio == PRIO_WR));
    grant_r   = pop_el & (~push_el | (prio == PRIO_RD));
    count_nxt = count;
    unique case (1'b1)
      grant_w: count_nxt = count + 1'b1;
      grant_r: count_nxt = count - 1'b1;
      default: ;
    endcase
  end

  assign push_ack    = grant_w;
  assign pop_ack     = grant_r;
  assign mem_wr_en   = grant_w;
  assign mem_rd_en   = grant_r;
  assign rd_data     = mem_rd_data;
  assign mem_wr_data = rst ? push_data : '0;

  // Idle cycles park the address on the read pointer.
  always_comb begin
    mem_addr = '0;
    if (rst) begin
      mem_addr = grant_w ? wr_ptr : rd_ptr;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      empty    <= 1'b1;
      full     <= 1'b0;
      rd_valid <= 1'b0;
      prio     <= PRIO_WR;
    end else begin
      if (grant_w) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (grant_r) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      count    <= count_nxt;
      full     <= (count_nxt == FULL_CNT);
      empty    <= (count_nxt == '0);
      rd_valid <= grant_r;
      if (push_el && pop_el) begin
        prio <= (prio == PRIO_WR) ? PRIO_RD : PRIO_WR;
      end
    end
  end

endmodule

// File: tb/tb_sp_fifo_ctrl.sv
// Bench for sp_fifo_ctrl with a behavioural 4x256 RAM.
// Table vectors plus hand-written full/wrap sequence.
module tb_sp_fifo_ctrl;

  logic       clk;
  logic       rst;
  logic       push_req;
  logic [3:0] push_data;
  logic       push_ack;
  logic       pop_req;
  logic       pop_ack;
  logic       rd_valid;
  logic [3:0] rd_data;
  logic       full;
  logic       empty;
  logic [8:0] count;
  logic       mem_wr_en;
  logic       mem_rd_en;
  logic [7:0] mem_addr;
  logic [3:0] mem_wr_data;
  logic [3:0] mem_rd_data;

  logic [3:0] ram [256];

  int n_chk;
  int n_fail;

  sp_fifo_ctrl #(
    .DATA_W(4),
    .ADDR_W(8),
    .DEPTH (256)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .push_req   (push_req),
    .push_data  (push_data),
    .push_ack   (push_ack),
    .pop_req    (pop_req),
    .pop_ack    (pop_ack),
    .rd_valid   (rd_valid),
    .rd_data    (rd_data),
    .full       (full),
    .empty      (empty),
    .count      (count),
    .mem_wr_en  (mem_wr_en),
    .mem_rd_en  (mem_rd_en),
    .mem_addr   (mem_addr),
    .mem_wr_data(mem_wr_data),
    .mem_rd_data(mem_rd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_wr_en) ram[mem_addr] <= mem_wr_data;
    if (mem_rd_en) mem_rd_data <= ram[mem_addr];
  end

  typedef struct {
    logic       r;
    logic       p;
    logic [3:0] d;
    logic       q;
    logic       pa;
    logic       ra;
    logic       we;
    logic       re;
    logic [7:0] a;
    logic [3:0] wd;
    logic [8:0] c;
    logic       e;
    logic       f;
    logic       rv;
    logic [3:0] rd;
  } vec_t;

  vec_t tbl [22];

  task automatic chk(input string n, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", n, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic p,
                       input logic [3:0] d, input logic q);
    rst       = r;
    push_req  = p;
    push_data = d;
    pop_req   = q;
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    drive(1'b0, 1'b0, 4'h0, 1'b0);
    mem_rd_data = 4'h0;

    // reset, gated requests
    tbl[0]  = '{0,1,5,1,  0,0,0,0,0,0,   0,1,0,0,0};
    tbl[1]  = '{0,0,0,0,  0,0,0,0,0,0,   0,1,0,0,0};
    // push 1,2,3 then pop x3
    tbl[2]  = '{1,1,1,0,  1,0,1,0,0,1,   1,0,0,0,0};
    tbl[3]  = '{1,1,2,0,  1,0,1,0,1,2,   2,0,0,0,0};
    tbl[4]  = '{1,1,3,0,  1,0,1,0,2,3,   3,0,0,0,0};
    tbl[5]  = '{1,0,0,1,  0,1,0,1,0,0,   2,0,0,1,1};
    tbl[6]  = '{1,0,0,1,  0,1,0,1,1,0,   1,0,0,1,2};
    tbl[7]  = '{1,0,0,1,  0,1,0,1,2,0,   0,1,0,1,3};
    tbl[8]  = '{1,0,0,0,  0,0,0,0,3,0,   0,1,0,0,0};
    // empty: lone pop refused, push+pop grants push only
    tbl[9]  = '{1,0,0,1,  0,0,0,0,3,0,   0,1,0,0,0};
    tbl[10] = '{1,1,7,1,  1,0,1,0,3,7,   1,0,0,0,0};
    // count=2 then contention W,R,W,R
    tbl[11] = '{1,1,8,0,  1,0,1,0,4,8,   2,0,0,0,0};
    tbl[12] = '{1,1,9,1,  1,0,1,0,5,9,   3,0,0,0,0};
    tbl[13] = '{1,1,10,1, 0,1,0,1,3,10,  2,0,0,1,7};
    tbl[14] = '{1,1,11,1, 1,0,1,0,6,11,  3,0,0,0,0};
    tbl[15] = '{1,1,12,1, 0,1,0,1,4,12,  2,0,0,1,8};
    tbl[16] = '{1,0,0,1,  0,1,0,1,5,0,   1,0,0,1,9};
    // reset right after a pop grant drops pending state
    tbl[17] = '{1,1,13,0, 1,0,1,0,7,13,  2,0,0,0,0};
    tbl[18] = '{1,0,0,1,  0,1,0,1,6,0,   1,0,0,1,11};
    tbl[19] = '{0,1,3,1,  0,0,0,0,0,0,   0,1,0,0,0};
    tbl[20] = '{1,1,4,0,  1,0,1,0,0,4,   1,0,0,0,0};
    tbl[21] = '{1,0,0,1,  0,1,0,1,0,0,   0,1,0,1,4};

    @(posedge clk);
    #1;

    for (int i = 0; i < 22; i++) begin
      drive(tbl[i].r, tbl[i].p, tbl[i].d, tbl[i].q);
      @(negedge clk);
      chk($sformatf("v%0d push_ack", i), int'(push_ack), int'(tbl[i].pa));
      chk($sformatf("v%0d pop_ack", i), int'(pop_ack), int'(tbl[i].ra));
      chk($sformatf("v%0d mem_wr_en", i), int'(mem_wr_en), int'(tbl[i].we));
      chk($sformatf("v%0d mem_rd_en", i), int'(mem_rd_en), int'(tbl[i].re));
      chk($sformatf("v%0d mem_addr", i), int'(mem_addr), int'(tbl[i].a));
      chk($sformatf("v%0d mem_wr_data", i), int'(mem_wr_data), int'(tbl[i].wd));
      chk($sformatf("v%0d wr_rd_excl", i), int'(mem_wr_en & mem_rd_en), 0);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d count", i), int'(count), int'(tbl[i].c));
      chk($sformatf("v%0d empty", i), int'(empty), int'(tbl[i].e));
      chk($sformatf("v%0d full", i), int'(full), int'(tbl[i].f));
      chk($sformatf("v%0d rd_valid", i), int'(rd_valid), int'(tbl[i].rv));
      if (tbl[i].rv) begin
        chk($sformatf("v%0d rd_data", i), int'(rd_data), int'(tbl[i].rd));
      end
    end

    // fill to 256 from a clean reset
    drive(1'b0, 1'b0, 4'h0, 1'b0);
    @(posedge clk);
    #1;
    for (int i = 0; i < 256; i++) begin
      drive(1'b1, 1'b1, 4'(i % 16), 1'b0);
      @(negedge clk);
      chk($sformatf("fill%0d push_ack", i), int'(push_ack), 1);
      chk($sformatf("fill%0d mem_addr", i), int'(mem_addr), i);
      @(posedge clk);
      #1;
    end
    chk("fill full", int'(full), 1);
    chk("fill count", int'(count), 256);
    chk("fill empty", int'(empty), 0);

    drive(1'b1, 1'b1, 4'h5, 1'b0);
    @(negedge clk);
    chk("push257 push_ack", int'(push_ack), 0);
    chk("push257 mem_wr_en", int'(mem_wr_en), 0);
    @(posedge clk);
    #1;
    chk("push257 count", int'(count), 256);

    // full with push+pop: pop alone is granted
    drive(1'b1, 1'b1, 4'h5, 1'b1);
    @(negedge clk);
    chk("fullpp push_ack", int'(push_ack), 0);
    chk("fullpp pop_ack", int'(pop_ack), 1);
    chk("fullpp mem_addr", int'(mem_addr), 0);
    @(posedge clk);
    #1;
    chk("fullpp rd_valid", int'(rd_valid), 1);
    chk("fullpp rd_data", int'(rd_data), 0);
    chk("fullpp count", int'(count), 255);
    chk("fullpp full", int'(full), 0);

    drive(1'b1, 1'b1, 4'hA, 1'b0);
    @(negedge clk);
    chk("wrap push_ack", int'(push_ack), 1);
    chk("wrap mem_addr", int'(mem_addr), 0);
    chk("wrap mem_wr_data", int'(mem_wr_data), 10);
    @(posedge clk);
    #1;
    chk("wrap full", int'(full), 1);
    chk("wrap count", int'(count), 256);

    drive(1'b1, 1'b0, 4'h0, 1'b1);
    @(negedge clk);
    chk("pop1 mem_addr", int'(mem_addr), 1);
    @(posedge clk);
    #1;
    chk("pop1 rd_data", int'(rd_data), 1);
    chk("pop1 count", int'(count), 255);

    drive(1'b1, 1'b0, 4'h0, 1'b0);
    @(posedge clk);
    #1;
    chk("pop1 rd_valid drop", int'(rd_valid), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
